// File: rtl/bow_lfsr.sv
// Free-running maximal-length Fibonacci LFSR (MSB-first) producing PRBS words
// for the BOW transmitter; STEP shifts are unrolled combinationally per clock.
module bow_lfsr #(
  parameter int unsigned WIDTH = 16,
  parameter logic [31:0] SEED  = 32'h0000_ACE1,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] y
);

  function automatic logic [31:0] tap(input int unsigned pos);
    return 32'(1) << (pos - 1);
  endfunction

  // 1-based tap positions of maximal-length polynomials; zero marks unsupported.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    case (w)
      3:       return tap(3)  | tap(2);
      4:       return tap(4)  | tap(3);
      5:       return tap(5)  | tap(3);
      6:       return tap(6)  | tap(5);
      7:       return tap(7)  | tap(6);
      8:       return tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:       return tap(9)  | tap(5);
      10:      return tap(10) | tap(7);
      11:      return tap(11) | tap(9);
      12:      return tap(12) | tap(6)  | tap(4)  | tap(1);
      13:      return tap(13) | tap(4)  | tap(3)  | tap(1);
      14:      return tap(14) | tap(5)  | tap(3)  | tap(1);
      15:      return tap(15) | tap(14);
      16:      return tap(16) | tap(15) | tap(13) | tap(4);
      17:      return tap(17) | tap(14);
      18:      return tap(18) | tap(11);
      19:      return tap(19) | tap(6)  | tap(2)  | tap(1);
      20:      return tap(20) | tap(17);
      21:      return tap(21) | tap(19);
      22:      return tap(22) | tap(21);
      23:      return tap(23) | tap(18);
      24:      return tap(24) | tap(23) | tap(22) | tap(17);
      25:      return tap(25) | tap(22);
      26:      return tap(26) | tap(6)  | tap(2)  | tap(1);
      27:      return tap(27) | tap(5)  | tap(2)  | tap(1);
      28:      return tap(28) | tap(25);
      29:      return tap(29) | tap(27);
      30:      return tap(30) | tap(6)  | tap(4)  | tap(1);
      31:      return tap(31) | tap(28);
      32:      return tap(32) | tap(22) | tap(2)  | tap(1);
      default: return '0;
    endcase
  endfunction

  localparam logic [31:0]      TAPS32   = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  if (TAPS32 == '0 || STEP < 1 || STEP > WIDTH) begin : g_bad_param
    $error("bow_lfsr: unsupported WIDTH or STEP");
  end

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_nxt;

  always_comb begin
    lfsr_nxt = lfsr_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      lfsr_nxt = {lfsr_nxt[WIDTH-2:0], ^(lfsr_nxt & TAPS)};
    end
  end

  // All-zero is the one state the shift cannot leave, so it reloads the seed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= SEED_EFF;
    end else if (lfsr_q == '0) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_nxt;
    end
  end

  assign y = lfsr_q;

endmodule

// File: tb/tb_bow_lfsr.sv
// Scoreboard bench for bow_lfsr: four builds (16-bit, 16-bit STEP=16, 4-bit, SEED=0)
// checked every clock against an arithmetic reference model.
module tb_bow_lfsr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] y16, y16s, y0;
  logic [3:0]  y4;

  always #5 clk = ~clk;

  bow_lfsr #(.WIDTH(16), .SEED(32'h0000_ACE1), .STEP(1))  u16  (.clk(clk), .reset_n(reset_n), .y(y16));
  bow_lfsr #(.WIDTH(16), .SEED(32'h0000_ACE1), .STEP(16)) u16s (.clk(clk), .reset_n(reset_n), .y(y16s));
  bow_lfsr #(.WIDTH(4),  .SEED(32'h0000_0001), .STEP(1))  u4   (.clk(clk), .reset_n(reset_n), .y(y4));
  bow_lfsr #(.WIDTH(16), .SEED(32'h0000_0000), .STEP(1))  u0   (.clk(clk), .reset_n(reset_n), .y(y0));

  typedef struct {
    longint e16;
    longint e16s;
    longint e4;
    longint e0;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint m16, m16s, m4, m0;
  bit     seen [0:65535];

  // Reference: Fibonacci shift from tap positions using plain integer arithmetic.
  function automatic longint ref_next(input longint s, input int w, input int n, input longint seed);
    int     t[4];
    longint v;
    longint fb;
    if (s == 0) return seed;
    case (w)
      16:      t = '{16, 15, 13, 4};
      4:       t = '{4, 3, 0, 0};
      default: t = '{0, 0, 0, 0};
    endcase
    v = s;
    for (int i = 0; i < n; i++) begin
      fb = 0;
      for (int j = 0; j < 4; j++)
        if (t[j] != 0) fb += (v / (longint'(1) << (t[j] - 1))) % 2;
      v = (v * 2 + fb % 2) % (longint'(1) << w);
    end
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.e16 = m16; e.e16s = m16s; e.e4 = m4; e.e0 = m0;
    sb.push_back(e);
  endtask

  task automatic advance_models(input logic r);
    if (!r) begin
      m16 = 'hACE1; m16s = 'hACE1; m4 = 1; m0 = 1;
    end else begin
      m16  = ref_next(m16, 16, 1, 'hACE1);
      m16s = ref_next(m16s, 16, 16, 'hACE1);
      m4   = ref_next(m4, 4, 1, 1);
      m0   = ref_next(m0, 16, 1, 1);
    end
  endtask

  task automatic drive_cycle(input logic r);
    @(negedge clk);
    reset_n = r;
    advance_models(r);
    push_exp();
  endtask

  // Monitor: every clock the DUTs present a word; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("y16",      longint'(y16),  e.e16);
        chk("y16_step", longint'(y16s), e.e16s);
        chk("y4",       longint'(y4),   e.e4);
        chk("y_seed0",  longint'(y0),   e.e0);
      end
    end
  end

  initial begin
    int first16, first4, zeros, dups;
    m16 = 0; m16s = 0; m4 = 0; m0 = 0;

    repeat (3) drive_cycle(1'b0);
    repeat (100) drive_cycle(1'b1);
    drive_cycle(1'b0);
    repeat (200) drive_cycle($urandom_range(0, 19) != 0);

    // Full period: seed must reappear exactly at cycle 2^16-1, with no zero or repeat.
    drive_cycle(1'b0);
    first16 = 0; first4 = 0; zeros = 0; dups = 0;
    for (int k = 1; k <= 65535; k++) begin
      drive_cycle(1'b1);
      @(posedge clk);
      #2;
      if (y16 == 16'h0000) zeros++;
      if (y4 == 4'h0) zeros++;
      if (seen[y16]) dups++;
      seen[y16] = 1'b1;
      if (first16 == 0 && y16 == 16'hACE1) first16 = k;
      if (first4 == 0 && y4 == 4'h1) first4 = k;
    end
    chk("period16", longint'(first16), 65535);
    chk("period4",  longint'(first4),  15);
    chk("zeros",    longint'(zeros),   0);
    chk("distinct", longint'(dups),    0);

    // Lockup: zero the main register, which must reload the seed on the next edge.
    @(negedge clk);
    force u16.lfsr_q = 16'h0000;
    #1;
    release u16.lfsr_q;
    reset_n = 1'b1;
    m16 = 0;
    advance_models(1'b1);
    push_exp();
    repeat (20) drive_cycle(1'b1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
